cu_read_line_unpacker: RTL and testbench



---
 rtl/cu_read_line_unpacker_pkg.sv | 49 ++++
 rtl/cu_line_elem_select.sv | 32 +++
 rtl/cu_read_line_unpacker.sv | 124 ++++++++++++
 tb/tb_cu_read_line_unpacker.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_read_line_unpacker_pkg.sv
// Shared types and constants for the CU read-line unpacker.
// Byte 0 of a line occupies the most significant byte of the flat line vector.
package cu_read_line_unpacker_pkg;

    localparam int CACHELINE_BYTES = 128;
    localparam int ELEM_BYTES      = 4;
    localparam int CU_ID_BITS      = 8;
    localparam int SIZE_W          = 12;

    localparam int LINE_BITS      = CACHELINE_BYTES * 8;
    localparam int ELEM_BITS      = ELEM_BYTES * 8;
    localparam int ELEMS_PER_LINE = CACHELINE_BYTES / ELEM_BYTES;
    localparam int ELEM_IDX_W     = $clog2(ELEMS_PER_LINE);
    localparam int LINE_IDX_W     = $clog2(LINE_BITS);
    localparam int CSIZE_W        = $clog2(CACHELINE_BYTES) + 1;
    localparam int DATA_OUT_W     = 1 + CU_ID_BITS + ELEM_BITS;

    typedef enum logic {
        UNPACK_IDLE,
        UNPACK_EMIT
    } unpacker_state_t;

    typedef logic [CU_ID_BITS-1:0] cu_id_t;

    typedef struct packed {
        logic                 valid;
        cu_id_t               cu_id;
        logic [SIZE_W-1:0]    size;
        logic [LINE_BITS-1:0] data;
    } read_line_in_t;

    typedef struct packed {
        logic                 valid;
        cu_id_t               cu_id;
        logic [ELEM_BITS-1:0] data;
    } data_read_t;

    function automatic logic [ELEM_BITS-1:0] swap_endianness_data_read(
        input logic [ELEM_BITS-1:0] d
    );
        logic [ELEM_BITS-1:0] r;
        r = '0;
        for (int i = 0; i < ELEM_BYTES; i++) begin
            r[8*i +: 8] = d[ELEM_BITS-8-8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/cu_line_elem_select.sv
// Picks element k of a held line, zeroes bytes past the request size,
// and returns it byte-swapped.
module cu_line_elem_select
    import cu_read_line_unpacker_pkg::*;
(
    input  logic [LINE_BITS-1:0]  line,
    input  logic [ELEM_IDX_W-1:0] k,
    input  logic [CSIZE_W-1:0]    size,
    output logic [ELEM_BITS-1:0]  elem
);

    logic [ELEM_IDX_W-1:0] idx_rev;
    logic [LINE_IDX_W-1:0] lo;
    logic [ELEM_BITS-1:0]  raw;
    logic [CSIZE_W-1:0]    pos;

    always_comb begin
        idx_rev = ELEM_IDX_W'(ELEMS_PER_LINE - 1) - k;
        lo      = LINE_IDX_W'(idx_rev) * LINE_IDX_W'(ELEM_BITS);
        raw     = line[lo +: ELEM_BITS];
        pos     = '0;
        // raw is MSB-first, so raw byte b is line byte k*ELEM_BYTES+b
        for (int b = 0; b < ELEM_BYTES; b++) begin
            pos = CSIZE_W'(k) * CSIZE_W'(ELEM_BYTES) + CSIZE_W'(b);
            if (pos >= size) begin
                raw[ELEM_BITS-8-8*b +: 8] = 8'h00;
            end
        end
        elem = swap_endianness_data_read(raw);
    end

endmodule

// File: rtl/cu_read_line_unpacker.sv
// Splits a read-response cache line into byte-swapped elements and
// streams them out one per cycle under ready/valid backpressure.
module cu_read_line_unpacker
    import cu_read_line_unpacker_pkg::*;
(
    input  logic                  clock,
    input  logic                  rstn,
    input  logic                  enabled_in,
    input  logic                  line_in_valid,
    output logic                  line_in_ready,
    input  logic [CU_ID_BITS-1:0] line_in_cu_id,
    input  logic [SIZE_W-1:0]     line_in_size,
    input  logic [LINE_BITS-1:0]  line_in_data,
    output logic [DATA_OUT_W-1:0] data_out,
    input  logic                  data_out_ready,
    output logic                  busy,
    output logic [31:0]           elements_emitted,
    output logic [15:0]           size_error_count
);

    unpacker_state_t       state_q;
    logic [LINE_BITS-1:0]  line_q;
    cu_id_t                cu_id_q;
    logic [CSIZE_W-1:0]    size_q;
    logic [ELEM_IDX_W-1:0] k_q;
    logic [ELEM_IDX_W-1:0] last_k_q;
    logic                  run_q;
    logic [31:0]           emitted_q;
    logic [15:0]           err_q;

    read_line_in_t         line_in;
    data_read_t            dout;
    logic [CSIZE_W-1:0]    size_c;
    logic [ELEM_IDX_W-1:0] last_k_d;
    logic [ELEM_BITS-1:0]  elem;
    logic                  valid;
    logic                  hs;
    logic                  last;
    logic                  accept;

    assign line_in = '{
        valid: line_in_valid,
        cu_id: line_in_cu_id,
        size:  line_in_size,
        data:  line_in_data
    };

    assign valid  = (state_q == UNPACK_EMIT);
    assign hs     = valid & data_out_ready;
    assign last   = (k_q == last_k_q);
    // run_q keeps ready low until the first edge after reset release
    assign line_in_ready = run_q & enabled_in &
                           ((state_q == UNPACK_IDLE) | (hs & last));
    assign accept = line_in.valid & line_in_ready;

    always_comb begin
        unique case (1'b1)
            (line_in.size > SIZE_W'(CACHELINE_BYTES)):
                size_c = CSIZE_W'(CACHELINE_BYTES);
            default:
                size_c = line_in.size[CSIZE_W-1:0];
        endcase
        last_k_d = ELEM_IDX_W'((size_c - CSIZE_W'(1)) / CSIZE_W'(ELEM_BYTES));
    end

    cu_line_elem_select u_sel (
        .line (line_q),
        .k    (k_q),
        .size (size_q),
        .elem (elem)
    );

    always_comb begin
        dout = '0;
        if (valid) begin
            dout.valid = 1'b1;
            dout.cu_id = cu_id_q;
            dout.data  = elem;
        end
    end

    assign data_out         = dout;
    assign busy             = valid;
    assign elements_emitted = emitted_q;
    assign size_error_count = err_q;

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state_q   <= UNPACK_IDLE;
            line_q    <= '0;
            cu_id_q   <= '0;
            size_q    <= '0;
            k_q       <= '0;
            last_k_q  <= '0;
            run_q     <= 1'b0;
            emitted_q <= '0;
            err_q     <= '0;
        end else begin
            run_q <= 1'b1;
            if (hs) begin
                emitted_q <= emitted_q + 32'd1;
                k_q       <= k_q + ELEM_IDX_W'(1);
                if (last) begin
                    state_q <= UNPACK_IDLE;
                end
            end
            if (accept) begin
                if (size_c == '0) begin
                    if (err_q != 16'hFFFF) begin
                        err_q <= err_q + 16'd1;
                    end
                end else begin
                    line_q   <= line_in.data;
                    cu_id_q  <= line_in.cu_id;
                    size_q   <= size_c;
                    last_k_q <= last_k_d;
                    k_q      <= '0;
                    state_q  <= UNPACK_EMIT;
                end
            end
        end
    end

endmodule

// File: tb/tb_cu_read_line_unpacker.sv
// Directed self-checking bench for cu_read_line_unpacker.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_cu_read_line_unpacker;

    logic          clock;
    logic          rstn;
    logic          enabled_in;
    logic          line_in_valid;
    logic          line_in_ready;
    logic [7:0]    line_in_cu_id;
    logic [11:0]   line_in_size;
    logic [1023:0] line_in_data;
    logic [40:0]   data_out;
    logic          data_out_ready;
    logic          busy;
    logic [31:0]   elements_emitted;
    logic [15:0]   size_error_count;

    int checks;
    int errors;

    cu_read_line_unpacker dut (
        .clock            (clock),
        .rstn             (rstn),
        .enabled_in       (enabled_in),
        .line_in_valid    (line_in_valid),
        .line_in_ready    (line_in_ready),
        .line_in_cu_id    (line_in_cu_id),
        .line_in_size     (line_in_size),
        .line_in_data     (line_in_data),
        .data_out         (data_out),
        .data_out_ready   (data_out_ready),
        .busy             (busy),
        .elements_emitted (elements_emitted),
        .size_error_count (size_error_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // byte j of a line sits at the top of the vector going down
    function automatic logic [1023:0] seq_line(input logic [7:0] start, input int nbytes);
        logic [1023:0] l;
        l = '0;
        for (int j = 0; j < nbytes; j++) begin
            l[1023-8*j -: 8] = start + 8'(j);
        end
        return l;
    endfunction

    function automatic logic [31:0] seq_beat(input logic [7:0] start, input int k);
        return {start + 8'(4*k+3), start + 8'(4*k+2), start + 8'(4*k+1), start + 8'(4*k)};
    endfunction

    task automatic do_reset();
        @(negedge clock);
        rstn = 1'b0;
        line_in_valid = 1'b0;
        @(negedge clock);
        rstn = 1'b1;
    endtask

    task automatic send_line(input logic [7:0] cu, input logic [11:0] sz, input logic [1023:0] d);
        @(posedge clock);
        #1;
        line_in_valid = 1'b1;
        line_in_cu_id = cu;
        line_in_size  = sz;
        line_in_data  = d;
        @(posedge clock);
        #1;
        line_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (line_in_ready !== 1'b0 || data_out !== 41'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b dout=%h busy=%b, want 0 0 0", line_in_ready, data_out, busy);
        end
        checks++;
        if (elements_emitted !== 32'd0 || size_error_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_counters: emitted=%0d err=%0d, want 0 0", elements_emitted, size_error_count);
        end
        @(negedge clock);
        checks++;
        if (line_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_held_ready: got %b want 0", line_in_ready);
        end
        line_in_valid = 1'b0;
        rstn = 1'b1;
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || data_out !== 41'd0 || line_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_idle: busy=%b dout=%h ready=%b, want 0 0 1", busy, data_out, line_in_ready);
        end
    endtask

    task automatic test_basic();
        logic [31:0] exp_d [4];
        exp_d = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
        do_reset();
        send_line(8'h05, 12'd16, seq_line(8'h00, 16));
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            checks++;
            if (data_out !== {1'b1, 8'h05, exp_d[k]}) begin
                errors++;
                $display("FAIL basic_beat%0d: got %h want %h", k, data_out, {1'b1, 8'h05, exp_d[k]});
            end
        end
        @(negedge clock);
        checks++;
        if (data_out[40] !== 1'b0 || busy !== 1'b0 || elements_emitted !== 32'd4) begin
            errors++;
            $display("FAIL basic_end: valid=%b busy=%b emitted=%0d, want 0 0 4", data_out[40], busy, elements_emitted);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_line(8'h21, 12'd128, seq_line(8'h00, 128));
        #1;
        line_in_valid = 1'b1;
        line_in_cu_id = 8'h22;
        line_in_size  = 12'd128;
        line_in_data  = seq_line(8'h80, 128);
        for (int k = 0; k < 32; k++) begin
            @(negedge clock);
            checks++;
            if (data_out !== {1'b1, 8'h21, seq_beat(8'h00, k)} || line_in_ready !== (k == 31)) begin
                errors++;
                $display("FAIL b2b_a_beat%0d: got %h rdy=%b want %h rdy=%b", k, data_out, line_in_ready,
                         {1'b1, 8'h21, seq_beat(8'h00, k)}, (k == 31));
            end
        end
        @(posedge clock);
        #1;
        line_in_valid = 1'b0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clock);
            checks++;
            if (data_out !== {1'b1, 8'h22, seq_beat(8'h80, k)}) begin
                errors++;
                $display("FAIL b2b_b_beat%0d: got %h want %h", k, data_out, {1'b1, 8'h22, seq_beat(8'h80, k)});
            end
        end
        @(negedge clock);
        checks++;
        if (data_out[40] !== 1'b0 || elements_emitted !== 32'd64) begin
            errors++;
            $display("FAIL b2b_end: valid=%b emitted=%0d, want 0 64", data_out[40], elements_emitted);
        end
    endtask

    task automatic test_short_size();
        logic [1023:0] l;
        l = '0;
        l[1023 -: 32] = 32'hAABBCCDD;
        do_reset();
        send_line(8'h3C, 12'd2, l);
        @(negedge clock);
        checks++;
        if (data_out !== {1'b1, 8'h3C, 32'h0000BBAA}) begin
            errors++;
            $display("FAIL short_beat: got %h want %h", data_out, {1'b1, 8'h3C, 32'h0000BBAA});
        end
        @(negedge clock);
        checks++;
        if (data_out[40] !== 1'b0 || elements_emitted !== 32'd1) begin
            errors++;
            $display("FAIL short_end: valid=%b emitted=%0d, want 0 1", data_out[40], elements_emitted);
        end
    endtask

    task automatic test_size_bounds();
        do_reset();
        send_line(8'h09, 12'd0, seq_line(8'h00, 128));
        @(negedge clock);
        checks++;
        if (data_out[40] !== 1'b0 || busy !== 1'b0 || size_error_count !== 16'd1) begin
            errors++;
            $display("FAIL size0: valid=%b busy=%b err=%0d, want 0 0 1", data_out[40], busy, size_error_count);
        end
        send_line(8'h0A, 12'd200, seq_line(8'h00, 128));
        for (int k = 0; k < 32; k++) begin
            @(negedge clock);
            checks++;
            if (data_out !== {1'b1, 8'h0A, seq_beat(8'h00, k)}) begin
                errors++;
                $display("FAIL size200_beat%0d: got %h want %h", k, data_out, {1'b1, 8'h0A, seq_beat(8'h00, k)});
            end
        end
        @(negedge clock);
        checks++;
        if (data_out[40] !== 1'b0 || elements_emitted !== 32'd32 || size_error_count !== 16'd1) begin
            errors++;
            $display("FAIL size200_end: valid=%b emitted=%0d err=%0d, want 0 32 1",
                     data_out[40], elements_emitted, size_error_count);
        end
    endtask

    task automatic test_backpressure();
        logic        rdy [6];
        int          bi  [6];
        rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        bi  = '{0, 1, 1, 1, 2, 3};
        do_reset();
        send_line(8'h11, 12'd16, seq_line(8'h40, 16));
        for (int c = 0; c < 6; c++) begin
            data_out_ready = rdy[c];
            @(negedge clock);
            checks++;
            if (data_out !== {1'b1, 8'h11, seq_beat(8'h40, bi[c])}) begin
                errors++;
                $display("FAIL stall_cyc%0d: got %h want %h", c, data_out, {1'b1, 8'h11, seq_beat(8'h40, bi[c])});
            end
            @(posedge clock);
            #1;
        end
        @(negedge clock);
        checks++;
        if (data_out[40] !== 1'b0 || elements_emitted !== 32'd4) begin
            errors++;
            $display("FAIL stall_end: valid=%b emitted=%0d, want 0 4", data_out[40], elements_emitted);
        end
    endtask

    task automatic test_disable();
        do_reset();
        send_line(8'h33, 12'd16, seq_line(8'h10, 16));
        #1;
        enabled_in    = 1'b0;
        line_in_valid = 1'b1;
        line_in_size  = 12'd16;
        line_in_data  = seq_line(8'h90, 16);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            checks++;
            if (data_out !== {1'b1, 8'h33, seq_beat(8'h10, k)} || line_in_ready !== 1'b0) begin
                errors++;
                $display("FAIL disable_beat%0d: got %h rdy=%b want %h rdy=0", k, data_out, line_in_ready,
                         {1'b1, 8'h33, seq_beat(8'h10, k)});
            end
        end
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (data_out[40] !== 1'b0 || busy !== 1'b0 || elements_emitted !== 32'd4) begin
            errors++;
            $display("FAIL disable_end: valid=%b busy=%b emitted=%0d, want 0 0 4", data_out[40], busy, elements_emitted);
        end
        line_in_valid = 1'b0;
        enabled_in    = 1'b1;
    endtask

    task automatic test_reset_midline();
        do_reset();
        send_line(8'h44, 12'd16, seq_line(8'h20, 16));
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checks++;
            if (data_out !== {1'b1, 8'h44, seq_beat(8'h20, k)}) begin
                errors++;
                $display("FAIL midrst_beat%0d: got %h want %h", k, data_out, {1'b1, 8'h44, seq_beat(8'h20, k)});
            end
        end
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (data_out !== 41'd0 || busy !== 1'b0 || elements_emitted !== 32'd0 || line_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async: dout=%h busy=%b emitted=%0d rdy=%b, want 0 0 0 0",
                     data_out, busy, elements_emitted, line_in_ready);
        end
        @(negedge clock);
        rstn = 1'b1;
        send_line(8'h77, 12'd8, seq_line(8'hC0, 8));
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            checks++;
            if (data_out !== {1'b1, 8'h77, seq_beat(8'hC0, k)}) begin
                errors++;
                $display("FAIL midrst_new%0d: got %h want %h", k, data_out, {1'b1, 8'h77, seq_beat(8'hC0, k)});
            end
        end
        @(negedge clock);
        checks++;
        if (data_out[40] !== 1'b0 || elements_emitted !== 32'd2) begin
            errors++;
            $display("FAIL midrst_end: valid=%b emitted=%0d, want 0 2", data_out[40], elements_emitted);
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rstn           = 1'b0;
        enabled_in     = 1'b1;
        line_in_valid  = 1'b1;
        line_in_cu_id  = 8'hEE;
        line_in_size   = 12'd64;
        line_in_data   = seq_line(8'h55, 128);
        data_out_ready = 1'b1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_short_size();
        test_size_bounds();
        test_backpressure();
        test_disable();
        test_reset_midline();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
